regfile_mp: RTL and testbench

Parametrised multi-port register file for the single-cycle and follow-on pipelined cores. It generalises the existing 32x32 two-read/one-write file to configurable width, depth and read-port count, with two prioritised write ports and write-through forwarding. It adds a per-register busy scoreboard so a pipelined core can detect pending long-latency writebacks, and an optional registered-read mode.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 67 ++++++
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port slicing helper for the multi-port register file.
package regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRP   = 2;

    // Low bit of port k inside a packed bus of w-bit lanes.
    function automatic int port_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int NRP      = DEF_NRP,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wen0,
    input  logic [AW-1:0]     waddr0,
    input  logic              wen1,
    input  logic [AW-1:0]     waddr1,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP-1:0]    rbusy,
    output logic              any_busy
);
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = rsv_en && (rsv_addr == AW'(gi));
            assign clr_hit = (wen0 && (waddr0 == AW'(gi))) || (wen1 && (waddr1 == AW'(gi)));
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_norm
                assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
            end
        end

        // Lookup sees this cycle's reserve/writeback so the pipeline never stalls on stale state.
        for (gi = 0; gi < NRP; gi++) begin : g_rport
            logic [AW-1:0] a;
            logic          b;
            assign a = raddr[port_lo(gi, AW) +: AW];
            always_comb begin
                b = busy_reg[a];
                if (ZERO_REG != 0 && a == '0) begin
                    b = 1'b0;
                end else if (rsv_en && rsv_addr == a) begin
                    b = 1'b1;
                end else if ((wen1 && waddr1 == a) || (wen0 && waddr0 == a)) begin
                    b = 1'b0;
                end
            end
            assign rbusy[gi] = b;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign any_busy = |busy_reg;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, write-through forwarding,
// busy scoreboard and optional registered read.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int NRP      = DEF_NRP,
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wen0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                wen1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                any_busy
);
    logic [XLEN-1:0]     mem [NREGS];
    logic                wr0_ok;
    logic                wr1_ok;
    logic [NRP*XLEN-1:0] fwd_data;
    logic [NRP-1:0]      fwd_busy;

    assign wr0_ok = wen0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1_ok = wen1 && !(ZERO_REG != 0 && waddr1 == '0);

    // Whole-array reset is required, so this maps to registers rather than block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr0_ok && !(wr1_ok && waddr1 == waddr0)) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_ok) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_fwd
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            assign a = raddr[port_lo(gi, AW) +: AW];
            always_comb begin
                d = mem[a];
                if (ZERO_REG != 0 && a == '0) begin
                    d = '0;
                end else if (wen1 && waddr1 == a) begin
                    d = wdata1;
                end else if (wen0 && waddr0 == a) begin
                    d = wdata0;
                end
            end
            assign fwd_data[port_lo(gi, XLEN) +: XLEN] = d;
        end

        if (READ_REG != 0) begin : g_rr
            logic [NRP*XLEN-1:0] rdata_reg;
            logic [NRP-1:0]      rbusy_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_reg <= '0;
                    rbusy_reg <= '0;
                end else begin
                    rdata_reg <= fwd_data;
                    rbusy_reg <= fwd_busy;
                end
            end
            assign rdata = rdata_reg;
            assign rbusy = rbusy_reg;
        end else begin : g_comb
            assign rdata = fwd_data;
            assign rbusy = fwd_busy;
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NRP      (NRP),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wen0     (wen0),
        .waddr0   (waddr0),
        .wen1     (wen1),
        .waddr1   (waddr1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr    (raddr),
        .rbusy    (fwd_busy),
        .any_busy (any_busy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: combinational-read 2-port instance and registered-read 4-port instance.
module tb_regfile_mp;
    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        wen0, wen1, rsv_en;
    logic [4:0]  waddr0, waddr1, rsv_addr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [1:0]  rbusy_a;
    logic        any_busy_a;
    logic [19:0] raddr_b;
    logic [127:0] rdata_b;
    logic [3:0]  rbusy_b;
    logic        any_busy_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NRP(2), .READ_REG(0)) dut_a (
        .clk(clk), .reset(reset),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy_a)
    );

    regfile_mp #(.NRP(4), .READ_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .any_busy(any_busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string note);
        @(posedge clk);
        #1;
        $display("[TB] t=%0t %s", $time, note);
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; rsv_en = 0;
        waddr0 = 0; waddr1 = 0; rsv_addr = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        raddr_a = '0;
        raddr_b = '0;
        step("reset");
        step("reset");
        reset = 1'b0;

        // Reset state: every register on every port of the combinational instance.
        for (int a = 0; a < 32; a++) begin
            raddr_a = {5'(31 - a), 5'(a)};
            #1;
            check($sformatf("rst_rd0_r%0d", a), rdata_a[31:0], 32'h0);
            check($sformatf("rst_rd1_r%0d", 31 - a), rdata_a[63:32], 32'h0);
            check($sformatf("rst_rb_r%0d", a), {30'h0, rbusy_a}, 32'h0);
        end
        check("rst_anybusy_a", {31'h0, any_busy_a}, 32'h0);
        check("rst_anybusy_b", {31'h0, any_busy_b}, 32'h0);
        raddr_b = {5'd4, 5'd3, 5'd2, 5'd1};
        step("read regs 1..4 on registered instance");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_b_rd%0d", k), rdata_b[k*32 +: 32], 32'h0);
        end
        check("rst_b_rbusy", {28'h0, rbusy_b}, 32'h0);

        // Write port 0 with same-cycle forwarding.
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        raddr_a = {5'd3, 5'd5};
        #1;
        check("fwd_w0_r5", rdata_a[31:0], 32'hDEADBEEF);
        check("fwd_w0_other", rdata_a[63:32], 32'h0);
        step("write r5=deadbeef");
        idle();
        #1;
        check("stored_r5", rdata_a[31:0], 32'hDEADBEEF);

        // Both ports to r7: port 1 wins in forwarding and storage.
        wen0 = 1; waddr0 = 7; wdata0 = 32'h11111111;
        wen1 = 1; waddr1 = 7; wdata1 = 32'h22222222;
        raddr_a = {5'd7, 5'd5};
        #1;
        check("fwd_dual_r7", rdata_a[63:32], 32'h22222222);
        check("fwd_dual_r5", rdata_a[31:0], 32'hDEADBEEF);
        step("dual write r7");
        idle();
        #1;
        check("stored_r7", rdata_a[63:32], 32'h22222222);

        // Distinct addresses on both write ports land independently.
        wen0 = 1; waddr0 = 10; wdata0 = 32'h0A0A0A0A;
        wen1 = 1; waddr1 = 11; wdata1 = 32'h0B0B0B0B;
        step("write r10,r11");
        idle();
        raddr_a = {5'd11, 5'd10};
        #1;
        check("stored_r10", rdata_a[31:0], 32'h0A0A0A0A);
        check("stored_r11", rdata_a[63:32], 32'h0B0B0B0B);

        // Scoreboard: reserve, clear by writeback, reserve beats same-cycle write.
        rsv_en = 1; rsv_addr = 9;
        raddr_a = {5'd5, 5'd9};
        #1;
        check("rsv_fwd_rbusy", {30'h0, rbusy_a}, 32'h1);
        check("rsv_anybusy_pre", {31'h0, any_busy_a}, 32'h0);
        step("reserve r9");
        idle();
        #1;
        check("rsv_rbusy", {30'h0, rbusy_a}, 32'h1);
        check("rsv_anybusy", {31'h0, any_busy_a}, 32'h1);
        wen0 = 1; waddr0 = 9; wdata0 = 32'h00000009;
        #1;
        check("wb_fwd_rbusy", {30'h0, rbusy_a}, 32'h0);
        check("wb_anybusy_pre", {31'h0, any_busy_a}, 32'h1);
        step("writeback r9");
        idle();
        #1;
        check("wb_rbusy", {30'h0, rbusy_a}, 32'h0);
        check("wb_anybusy", {31'h0, any_busy_a}, 32'h0);
        check("wb_r9", rdata_a[31:0], 32'h00000009);
        rsv_en = 1; rsv_addr = 9;
        wen1 = 1; waddr1 = 9; wdata1 = 32'h0000AAAA;
        #1;
        check("rsvwr_fwd_rbusy", {30'h0, rbusy_a}, 32'h1);
        step("reserve+write r9");
        idle();
        #1;
        check("rsvwr_rbusy", {30'h0, rbusy_a}, 32'h1);
        check("rsvwr_anybusy", {31'h0, any_busy_a}, 32'h1);
        check("rsvwr_r9", rdata_a[31:0], 32'h0000AAAA);
        wen0 = 1; waddr0 = 9; wdata0 = 32'h0000AAAA;
        step("clear r9");
        idle();
        #1;
        check("clr_anybusy", {31'h0, any_busy_a}, 32'h0);

        // Register 0 ignores writes and reserves.
        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
        wen1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
        rsv_en = 1; rsv_addr = 0;
        raddr_a = {5'd0, 5'd0};
        #1;
        check("z_fwd_rd0", rdata_a[31:0], 32'h0);
        check("z_fwd_rbusy", {30'h0, rbusy_a}, 32'h0);
        step("write/reserve r0");
        idle();
        #1;
        check("z_rd1", rdata_a[63:32], 32'h0);
        check("z_rbusy", {30'h0, rbusy_a}, 32'h0);
        check("z_anybusy", {31'h0, any_busy_a}, 32'h0);

        // Registered-read instance: one cycle latency.
        raddr_b = {5'd0, 5'd9, 5'd7, 5'd5};
        step("b present 5,7,9,0");
        raddr_b = {5'd5, 5'd0, 5'd9, 5'd7};
        #1;
        check("b_c1_p0", rdata_b[31:0],   32'hDEADBEEF);
        check("b_c1_p1", rdata_b[63:32],  32'h22222222);
        check("b_c1_p2", rdata_b[95:64],  32'h0000AAAA);
        check("b_c1_p3", rdata_b[127:96], 32'h0);
        step("b present 7,9,0,5");
        check("b_c2_p0", rdata_b[31:0],   32'h22222222);
        check("b_c2_p1", rdata_b[63:32],  32'h0000AAAA);
        check("b_c2_p2", rdata_b[95:64],  32'h0);
        check("b_c2_p3", rdata_b[127:96], 32'hDEADBEEF);
        wen0 = 1; waddr0 = 12; wdata0 = 32'h12345678;
        rsv_en = 1; rsv_addr = 3;
        raddr_b = {5'd3, 5'd12, 5'd11, 5'd10};
        step("b fwd write r12 + reserve r3");
        idle();
        check("b_c3_p0", rdata_b[31:0],   32'h0A0A0A0A);
        check("b_c3_p1", rdata_b[63:32],  32'h0B0B0B0B);
        check("b_c3_p2", rdata_b[95:64],  32'h12345678);
        check("b_c3_rbusy", {28'h0, rbusy_b}, 32'h8);
        check("b_c3_anybusy", {31'h0, any_busy_b}, 32'h1);

        // Reset mid-stream dominates a concurrent write and reserve.
        reset = 1;
        wen0 = 1; waddr0 = 20; wdata0 = 32'h55555555;
        rsv_en = 1; rsv_addr = 21;
        raddr_b = {5'd12, 5'd9, 5'd7, 5'd5};
        step("reset mid-stream");
        reset = 0;
        idle();
        check("mr_b_rdata_lo", rdata_b[63:0] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        check("mr_b_rdata_hi", rdata_b[127:64] == 64'h0 ? 32'h0 : 32'h1, 32'h0);
        check("mr_b_rbusy", {28'h0, rbusy_b}, 32'h0);
        check("mr_b_anybusy", {31'h0, any_busy_b}, 32'h0);
        raddr_a = {5'd21, 5'd20};
        #1;
        check("mr_a_r20", rdata_a[31:0], 32'h0);
        check("mr_a_rbusy", {30'h0, rbusy_a}, 32'h0);
        check("mr_a_anybusy", {31'h0, any_busy_a}, 32'h0);
        raddr_a = {5'd7, 5'd5};
        #1;
        check("mr_a_r5", rdata_a[31:0], 32'h0);
        check("mr_a_r7", rdata_a[63:32], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
